pmt_trigger_readout: RTL

- Sits between the ADC sample stream and the PMT ring buffer, and owns that buffer's write enable and read port.
- Watches ADC samples for a threshold crossing, then waits for POST post-trigger samples.
- Freezes writing and reads back a PRE+POST sample window ending at the final post-trigger sample, handing it to the event packer over a valid/ready stream.
- Dead time: writes are frozen from freeze until the last word is accepted.

---
 rtl/pmt_trigger_readout_if.sv | 23 ++
 rtl/pmt_trigger_readout.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pmt_trigger_readout_if.sv
// Window readout stream towards the event packer.
// Carries one ring buffer sample per valid/ready beat.
interface pmt_trigger_readout_if #(
  parameter int WIDTH = 14
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_first;
  logic             out_last;

  modport master (
    output out_data, out_valid,
    output out_first, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid,
    input  out_first, out_last,
    output out_ready
  );
endinterface

// File: rtl/pmt_trigger_readout.sv
// PMT threshold trigger with pre/post window readout.
// Owns ring buffer write gating and read port.
module pmt_trigger_readout #(
  parameter int SIZE  = 12,
  parameter int WIDTH = 14,
  parameter int PRE   = 16,
  parameter int POST  = 48,
  parameter int CNTW  = 16
) (
  input  logic                sysclk,
  input  logic                rst,
  input  logic                adc_valid,
  input  logic [WIDTH-1:0]    adc_din,
  input  logic [WIDTH-1:0]    thresh,
  output logic                rb_wr_en,
  input  logic [SIZE-1:0]     rb_aout,
  output logic [SIZE-1:0]     rb_ain,
  output logic                rb_rd_en,
  input  logic [WIDTH-1:0]    rb_dout,
  pmt_trigger_readout_if.master out,
  output logic                busy,
  output logic [CNTW-1:0]     event_count,
  output logic [CNTW-1:0]     missed_count
);

  localparam int WIN = PRE + POST;
  localparam int FW  = $clog2(PRE + 1);
  localparam int PW  = $clog2(POST + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POST,
    S_FREEZE,
    S_RD_ADDR,
    S_RD_EN,
    S_OUT
  } state_t;

  state_t           state_q, state_d;
  logic [FW-1:0]    fill_q;
  logic [PW-1:0]    post_q;
  logic [SIZE-1:0]  base_q;
  logic [SIZE-1:0]  idx_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             first_q;
  logic             last_q;
  logic [CNTW-1:0]  event_q;
  logic [CNTW-1:0]  missed_q;

  logic armed;
  logic trig;
  logic accept;
  logic idx_last;
  logic post_done;

  assign armed     = (fill_q == FW'(PRE));
  assign trig      = rb_wr_en & (adc_din > thresh);
  assign accept    = valid_q & out.out_ready;
  assign idx_last  = (idx_q == SIZE'(WIN - 1));
  assign post_done = (post_q == PW'(POST - 1));

  assign out.out_data  = data_q;
  assign out.out_valid = valid_q;
  assign out.out_first = first_q;
  assign out.out_last  = last_q;
  assign event_count   = event_q;
  assign missed_count  = missed_q;

  // State register; reset drops any window in flight.
  always_ff @(posedge sysclk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state: arm, collect post samples, then walk the window.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (trig && armed)
          state_d = (POST == 1) ? S_FREEZE : S_POST;
      end
      S_POST: begin
        if (rb_wr_en && post_done)
          state_d = S_FREEZE;
      end
      S_FREEZE:  state_d = S_RD_ADDR;
      S_RD_ADDR: state_d = S_RD_EN;
      S_RD_EN:   state_d = S_OUT;
      S_OUT: begin
        if (accept)
          state_d = idx_last ? S_IDLE : S_RD_ADDR;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Ring buffer control: writes only while collecting samples.
  always_comb begin
    rb_wr_en = 1'b0;
    rb_rd_en = 1'b0;
    rb_ain   = '0;
    busy     = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE, S_POST: rb_wr_en = adc_valid & ~rst;
      S_RD_ADDR, S_OUT: rb_ain = base_q + idx_q;
      S_RD_EN: begin
        rb_ain   = base_q + idx_q;
        rb_rd_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Counters, window base and the held output word.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      fill_q   <= '0;
      post_q   <= '0;
      base_q   <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      event_q  <= '0;
      missed_q <= '0;
    end else begin
      if (state_q == S_OUT && accept && idx_last)
        fill_q <= '0;
      else if (rb_wr_en && !armed)
        fill_q <= fill_q + FW'(1);

      if (state_q == S_IDLE && trig && armed)
        post_q <= PW'(1);
      else if (state_q == S_POST && rb_wr_en)
        post_q <= post_q + PW'(1);

      if (trig && !(state_q == S_IDLE && armed)
          && missed_q != '1)
        missed_q <= missed_q + CNTW'(1);

      if (state_q == S_FREEZE) begin
        base_q <= rb_aout - SIZE'(WIN);
        idx_q  <= '0;
      end

      if (state_q == S_OUT) begin
        if (!valid_q) begin
          data_q  <= rb_dout;
          valid_q <= 1'b1;
          first_q <= (idx_q == '0);
          last_q  <= idx_last;
        end else if (out.out_ready) begin
          valid_q <= 1'b0;
          first_q <= 1'b0;
          last_q  <= 1'b0;
          if (idx_last) event_q <= event_q + CNTW'(1);
          else          idx_q   <= idx_q + SIZE'(1);
        end
      end
    end
  end

endmodule
